d_mem_io: RTL and testbench

//  Data-memory stage directly downstream of cpu_ctrl: consumes d_mem_addr, d_mem_addr_mode
//  and en_d_mem, and returns the operand word to the datapath B-input mux.

---
 rtl/d_mem_io.sv | 121 ++++++++++++
 tb/tb_d_mem_io.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/d_mem_io.sv
// d_mem_io: data memory with direct/indirect addressing, a memory-mapped
// output FIFO (valid/ready) at OUT_ADDR and a status register at STAT_ADDR.
// Ports: clk, rst (async active-low), d_mem_addr, d_mem_addr_mode, en_d_mem,
//   data_in, data_out (combinational read), io_out_data/valid/ready, io_overflow.
module d_mem_io #(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] OUT_ADDR   = {WIDTH{1'b1}},
    parameter logic [WIDTH-1:0] STAT_ADDR  = {{(WIDTH-1){1'b1}}, 1'b0},
    parameter int               FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_mem_addr,
    input  logic             d_mem_addr_mode,
    input  logic             en_d_mem,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic [WIDTH-1:0] io_out_data,
    output logic             io_out_valid,
    input  logic             io_out_ready,
    output logic             io_overflow
);

    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam int CW    = PW + 1;
    localparam int DEPTH = 2 ** WIDTH;

    logic [WIDTH-1:0] ram_q  [DEPTH];
    logic [WIDTH-1:0] fifo_q [FIFO_DEPTH];
    logic [PW-1:0]    rd_ptr_q;
    logic [PW-1:0]    wr_ptr_q;
    logic [CW-1:0]    count_q;
    logic             ovf_q;

    logic [WIDTH-1:0] stat_word;
    logic [WIDTH-1:0] ptr_word;
    logic [WIDTH-1:0] ea;
    logic             full;
    logic             do_pop;
    logic             do_push;
    logic             wr_out;
    logic             wr_stat;
    logic             wr_ram;

    // Status: overflow flag in the MSB, occupancy count LSB-aligned.
    always_comb begin
        stat_word            = '0;
        stat_word[CW-1:0]    = count_q;
        stat_word[WIDTH-1]   = ovf_q;
    end

    // Two identical read decoders: one resolves the pointer for indirect
    // mode, the second returns the operand at the effective address.
    always_comb begin
        ptr_word = '0;
        unique case (1'b1)
            d_mem_addr == STAT_ADDR: ptr_word = stat_word;
            d_mem_addr == OUT_ADDR:  ptr_word = '0;
            default:                 ptr_word = ram_q[d_mem_addr];
        endcase
        ea = d_mem_addr_mode ? ptr_word : d_mem_addr;
    end

    always_comb begin
        data_out = '0;
        unique case (1'b1)
            ea == STAT_ADDR: data_out = stat_word;
            ea == OUT_ADDR:  data_out = '0;
            default:         data_out = ram_q[ea];
        endcase
    end

    assign full     = (count_q == CW'(FIFO_DEPTH));
    assign wr_out   = en_d_mem && (ea == OUT_ADDR);
    assign wr_stat  = en_d_mem && (ea == STAT_ADDR);
    assign wr_ram   = en_d_mem && !wr_out && !wr_stat;
    assign do_pop   = io_out_valid && io_out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push  = wr_out && (!full || do_pop);

    assign io_out_valid = (count_q != '0);
    assign io_out_data  = io_out_valid ? fifo_q[rd_ptr_q] : '0;
    assign io_overflow  = ovf_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) ram_q[i] <= '0;
        end else if (wr_ram) begin
            ram_q[ea] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (do_push) begin
                fifo_q[wr_ptr_q] <= data_in;
                wr_ptr_q         <= wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            if (wr_stat) begin
                ovf_q <= 1'b0;
            end else if (wr_out && full && !do_pop) begin
                ovf_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_d_mem_io.sv
// tb_d_mem_io: directed and randomized checks of d_mem_io against a
// queue/array reference model.
module tb_d_mem_io;

    logic       clk;
    logic       rst;
    logic [7:0] d_mem_addr;
    logic       d_mem_addr_mode;
    logic       en_d_mem;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic [7:0] io_out_data;
    logic       io_out_valid;
    logic       io_out_ready;
    logic       io_overflow;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] mram [256];
    logic [7:0] mq   [$];
    logic       movf;

    d_mem_io dut (
        .clk             (clk),
        .rst             (rst),
        .d_mem_addr      (d_mem_addr),
        .d_mem_addr_mode (d_mem_addr_mode),
        .en_d_mem        (en_d_mem),
        .data_in         (data_in),
        .data_out        (data_out),
        .io_out_data     (io_out_data),
        .io_out_valid    (io_out_valid),
        .io_out_ready    (io_out_ready),
        .io_overflow     (io_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] m_rd(input logic [7:0] a);
        if (a == 8'hFE) return {movf, 4'b0, 3'(mq.size())};
        if (a == 8'hFF) return 8'h00;
        return mram[a];
    endfunction

    function automatic logic [7:0] m_ea(input logic [7:0] a, input logic m);
        return m ? m_rd(a) : a;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 256; i++) mram[i] = 8'h00;
        mq.delete();
        movf = 1'b0;
    endtask

    // Compare every output against the model for the inputs now applied.
    task automatic chk_all(input string tag);
        logic [7:0] ea;
        ea = m_ea(d_mem_addr, d_mem_addr_mode);
        chk({tag, ".dout"}, data_out, m_rd(ea));
        chk({tag, ".valid"}, {7'b0, io_out_valid}, {7'b0, mq.size() != 0});
        chk({tag, ".head"}, io_out_data,
            (mq.size() != 0) ? mq[0] : 8'h00);
        chk({tag, ".ovf"}, {7'b0, io_overflow}, {7'b0, movf});
    endtask

    // Model state after one clock edge with the current inputs.
    task automatic m_edge();
        logic [7:0] ea;
        ea = m_ea(d_mem_addr, d_mem_addr_mode);
        if (io_out_ready && mq.size() != 0) void'(mq.pop_front());
        if (en_d_mem) begin
            if (ea == 8'hFF) begin
                if (mq.size() < 4) mq.push_back(data_in);
                else movf = 1'b1;
            end else if (ea == 8'hFE) begin
                movf = 1'b0;
            end else begin
                mram[ea] = data_in;
            end
        end
    endtask

    task automatic cyc(input logic [7:0] a, input logic m, input logic e,
                       input logic [7:0] d, input logic r, input string tag);
        d_mem_addr      = a;
        d_mem_addr_mode = m;
        en_d_mem        = e;
        data_in         = d;
        io_out_ready    = r;
        #1;
        chk_all(tag);
        m_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic peek(input logic [7:0] a, input logic m, input logic r);
        d_mem_addr      = a;
        d_mem_addr_mode = m;
        en_d_mem        = 1'b0;
        data_in         = 8'h00;
        io_out_ready    = r;
        #1;
    endtask

    function automatic logic [7:0] pick();
        int unsigned r;
        r = $urandom_range(0, 9);
        if (r == 8) return 8'hFE;
        if (r == 9) return 8'hFF;
        return 8'(r);
    endfunction

    logic [7:0] exp4 [4];

    initial begin
        m_reset();
        rst = 1'b0;
        peek(8'h10, 1'b0, 1'b0);
        chk_all("reset");
        peek(8'hFE, 1'b0, 1'b0);
        chk("reset.stat", data_out, 8'h00);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Direct write then read back.
        cyc(8'h10, 1'b0, 1'b1, 8'h5A, 1'b0, "t1w");
        peek(8'h10, 1'b0, 1'b0);
        chk("t1.rd", data_out, 8'h5A);

        // Indirect read and write through ram[0x20] -> 0x30.
        cyc(8'h20, 1'b0, 1'b1, 8'h30, 1'b0, "t2a");
        cyc(8'h30, 1'b0, 1'b1, 8'hC3, 1'b0, "t2b");
        peek(8'h20, 1'b1, 1'b0);
        chk("t2.ind", data_out, 8'hC3);
        cyc(8'h20, 1'b1, 1'b1, 8'h77, 1'b0, "t2w");
        peek(8'h30, 1'b0, 1'b0);
        chk("t2.ram30", data_out, 8'h77);
        peek(8'h20, 1'b0, 1'b0);
        chk("t2.ram20", data_out, 8'h30);

        // Fill FIFO, overflow, clear.
        for (int k = 1; k <= 4; k++)
            cyc(8'hFF, 1'b0, 1'b1, 8'(k), 1'b0, "t3p");
        peek(8'hFE, 1'b0, 1'b0);
        chk("t3.stat", data_out, 8'h04);
        chk("t3.head", io_out_data, 8'h01);
        chk("t3.valid", {7'b0, io_out_valid}, 8'h01);
        cyc(8'hFF, 1'b0, 1'b1, 8'h05, 1'b0, "t3o");
        peek(8'hFE, 1'b0, 1'b0);
        chk("t3.ovfstat", data_out, 8'h84);
        chk("t3.ovf", {7'b0, io_overflow}, 8'h01);
        cyc(8'hFE, 1'b0, 1'b1, 8'h00, 1'b0, "t3c");
        peek(8'hFE, 1'b0, 1'b0);
        chk("t3.clr", data_out, 8'h04);

        // Push and pop together while full.
        cyc(8'hFF, 1'b0, 1'b1, 8'h09, 1'b1, "t4pp");
        peek(8'hFE, 1'b0, 1'b0);
        chk("t4.stat", data_out, 8'h04);
        chk("t4.head", io_out_data, 8'h02);
        exp4[0] = 8'h02; exp4[1] = 8'h03; exp4[2] = 8'h04; exp4[3] = 8'h09;
        for (int k = 0; k < 4; k++) begin
            peek(8'h00, 1'b0, 1'b1);
            chk("t4.drain", io_out_data, exp4[k]);
            cyc(8'h00, 1'b0, 1'b0, 8'h00, 1'b1, "t4d");
        end
        chk("t4.empty", {7'b0, io_out_valid}, 8'h00);

        // Streaming through the pointer wrap.
        for (int k = 0; k < 10; k++) begin
            cyc(8'hFF, 1'b0, 1'b1, 8'(8'h20 + k), 1'b1, "t5");
            chk("t5.head", io_out_data, 8'(8'h20 + k));
            chk("t5.ovf", {7'b0, io_overflow}, 8'h00);
        end
        cyc(8'h00, 1'b0, 1'b0, 8'h00, 1'b1, "t5e");
        chk("t5.valid", {7'b0, io_out_valid}, 8'h00);

        // Asynchronous reset with three words queued.
        for (int k = 0; k < 3; k++)
            cyc(8'hFF, 1'b0, 1'b1, 8'(8'hA0 + k), 1'b0, "t6p");
        #2;
        rst = 1'b0;
        m_reset();
        peek(8'hFE, 1'b0, 1'b0);
        chk("t6.stat", data_out, 8'h00);
        chk("t6.valid", {7'b0, io_out_valid}, 8'h00);
        chk("t6.head", io_out_data, 8'h00);
        peek(8'h10, 1'b0, 1'b0);
        chk("t6.ram", data_out, 8'h00);
        d_mem_addr = 8'h10;
        en_d_mem   = 1'b1;
        data_in    = 8'h55;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        peek(8'h10, 1'b0, 1'b0);
        chk("t6.nowr", data_out, 8'h00);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++)
            cyc(pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                pick(), 1'($urandom_range(0, 2) == 0), "rnd");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
